ps2_keymap_rx: RTL and testbench
================================

Name: ps2_keymap_rx

Overview:
- Parametrised successor to the two-player PS/2 keyboard decoder.
- Samples PS/2 clock and data entirely in the `clk` domain: synchronise, glitch-filter, detect falling edges, assemble frames.
- Checks start, odd parity and stop bits. Decodes F0 (break) and E0 (extended) prefixes against a parameter key table of NUM_KEYS entries.
- Outputs held-key levels and press/release event pulses to game logic (tank control, menu yes/no).

Parameters:
- NUM_KEYS, 12, number of mapped keys (1..32).
- KEY_CODES, 12 x 9-bit packed {ext, code}, default W,S,A,D,Space,I,K,J,L,Enter,N,Y with ext=0; entry i occupies bits [9i+8:9i].
- CLK_HZ, 100_000_000, system clock frequency.
- TIMEOUT_US, 2000, maximum gap between PS/2 falling edges inside a frame.
- FILT_LEN, 8, consecutive equal samples needed before the filtered line value changes (2..255).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- kclk  in  1  raw PS/2 clock (asynchronous)
- kdata  in  1  raw PS/2 data (asynchronous)
- key_held  out  NUM_KEYS  level, 1 while key i is down
- key_press  out  NUM_KEYS  one-cycle pulse on make of key i (first make only)
- key_release  out  NUM_KEYS  one-cycle pulse on break of key i
- scan_valid  out  1  one-cycle pulse, a good byte was received
- scan_code  out  8  last good byte, held until the next good byte
- frame_err  out  1  one-cycle pulse on parity, start, stop or timeout error

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `rst`.
- Reset values: all outputs 0; frame FSM in IDLE; brk and ext flags 0; filtered lines preset to 1 (idle high); timeout counter 0.
- Line filter:
  - Two-flop synchroniser per line.
  - Filtered value changes only after FILT_LEN consecutive equal synchronised samples.
  - kfall = filtered kclk 1->0, one-cycle strobe.
- Frame FSM (state advances only on kfall):
  - IDLE: start bit sampled. If data=0, go to DATA with bit count 0. If data=1, ignore and stay in IDLE (no error).
  - DATA: shift data LSB first; after 8 bits go to PARITY.
  - PARITY: store the parity bit; go to STOP.
  - STOP: if stop=1 and parity of data+parity bit is odd, the byte is good; otherwise pulse frame_err. Always return to IDLE.
- Timeout:
  - Counter of TIMEOUT_CYC = CLK_HZ/1_000_000*TIMEOUT_US cycles.
  - Cleared on every kfall and while in IDLE.
  - On reaching TIMEOUT_CYC outside IDLE: pulse frame_err, go to IDLE, clear brk and ext.
- Good byte (cycle after the STOP kfall, latency 1 clk):
  - scan_valid=1 and scan_code=byte.
  - Key outputs update in the same cycle.
- Decode of a good byte:
  - 0xF0 sets brk.
  - 0xE0 sets ext.
  - Any other byte matches every entry i with KEY_CODES[i] == {ext, byte}:
    - brk=0: key_held[i]<=1; key_press[i] pulses only if key_held[i] was 0 (typematic repeats suppressed).
    - brk=1: key_held[i]<=0; key_release[i] pulses only if key_held[i] was 1.
  - brk and ext clear after any non-prefix byte, matched or not.
  - No match: key state unchanged.
  - Duplicate table entries all update.
- Any frame_err: clear brk and ext; key_held unchanged.
- Reset mid-frame: the partial frame is discarded; no pulses are generated.

Optional Feature:
- Macro: PS2_KEYMAP_EXT_KEYS_EN.
- Defined:
  - ext table bit is honoured.
  - E0 75 matches entry {1,0x75} (arrow up) and not {0,0x75} (keypad 8).
- Undefined:
  - ext table bits are ignored.
  - On E0, set a discard flag; the next non-prefix byte, including a following F0, is consumed without any key update, then the flags clear.
  - scan_valid still pulses for every good byte.

Decomposition:
- Package ps2_pkg:
  - PS2_BRK=8'hF0, PS2_EXT=8'hE0.
  - Frame state enum {IDLE, DATA, PARITY, STOP}.
  - KEYCODE_W=9.
  - Default key-code constants.
- One sub-module, ps2_line_filter: synchroniser, FILT_LEN filter and falling-edge strobe; one instance per line.
- Frame FSM and decode stay in ps2_keymap_rx.

Test Plan:
- Reset, then frame 0x1D with good parity and stop -> scan_valid=1, scan_code=0x1D, key_held[0]=1 and key_press[0] pulses, both 1 clk after the stop kfall.
- Repeat the 0x1D make x3, then F0 1D -> key_press pulses once only; key_release[0] pulses once; key_held[0]=0.
- Frame 0x29 with wrong parity -> frame_err pulse, no scan_valid, key_held unchanged. Then F0 then stop after 6 data bits -> frame_err after TIMEOUT_CYC cycles; the next 0x1B is decoded as a make, not a break.
- 3-cycle glitch pulses on kclk with FILT_LEN=8 -> no bit sampled, FSM stays IDLE.
- With the macro defined and KEY_CODES entry 0={1,0x75}, entry 1={0,0x75}: E0 75 -> only key_held[0]=1; 75 -> key_held[1]=1. Without the macro, E0 75 -> no key change, scan_valid pulses twice.
- Assert rst at DATA bit 4 -> outputs 0; the next complete 0x5A frame -> key_press[9] pulses.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard receiver definitions: prefix bytes, frame states, key-code layout.
// Default key table: W,S,A,D,Space,I,K,J,L,Enter,N,Y (all non-extended), entry 0 in the LSBs.
// Optional build macro used by ps2_keymap_rx: PS2_KEYMAP_EXT_KEYS_EN.
package ps2_pkg;

  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;

  // One table entry is {ext, code}.
  localparam int KEYCODE_W = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  // Set-2 make codes for the default two-player layout.
  localparam logic [KEYCODE_W-1:0] KEY_W     = 9'h01D;
  localparam logic [KEYCODE_W-1:0] KEY_S     = 9'h01B;
  localparam logic [KEYCODE_W-1:0] KEY_A     = 9'h01C;
  localparam logic [KEYCODE_W-1:0] KEY_D     = 9'h023;
  localparam logic [KEYCODE_W-1:0] KEY_SPACE = 9'h029;
  localparam logic [KEYCODE_W-1:0] KEY_I     = 9'h043;
  localparam logic [KEYCODE_W-1:0] KEY_K     = 9'h042;
  localparam logic [KEYCODE_W-1:0] KEY_J     = 9'h03B;
  localparam logic [KEYCODE_W-1:0] KEY_L     = 9'h04B;
  localparam logic [KEYCODE_W-1:0] KEY_ENTER = 9'h05A;
  localparam logic [KEYCODE_W-1:0] KEY_N     = 9'h031;
  localparam logic [KEYCODE_W-1:0] KEY_Y     = 9'h035;

  // Entry i occupies bits [9i+8:9i]; the concatenation lists entry 11 first.
  localparam logic [12*KEYCODE_W-1:0] KEY_CODES_DEFAULT = {
    KEY_Y, KEY_N, KEY_ENTER, KEY_L, KEY_J, KEY_K,
    KEY_I, KEY_SPACE, KEY_D, KEY_A, KEY_S, KEY_W
  };

  // True when the eight data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises one raw PS/2 line into clk, debounces it and strobes on its falling edge.
// Latency: 2 sync flops plus FILT_LEN samples before the filtered level (and the strobe) changes.
// No backpressure: the strobe is a single-cycle pulse coincident with the filtered 1->0 change.
module ps2_line_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt,
  output logic fall
);

  logic [1:0] sync;
  logic [7:0] run_cnt;

  // Two-flop synchroniser, preset to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], raw};
    end
  end

  // Count consecutive samples that disagree with the filtered level; flip once FILT_LEN agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt    <= 1'b1;
      run_cnt <= '0;
      fall    <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (sync[1] != filt) begin
        if (run_cnt == 8'(FILT_LEN - 1)) begin
          filt    <= sync[1];
          run_cnt <= '0;
          // Disagreeing while filt is 1 means the line is settling low.
          fall    <= filt;
        end else begin
          run_cnt <= run_cnt + 8'd1;
        end
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_keymap_rx.sv
// PS/2 keyboard receiver: frames bytes, handles F0/E0 prefixes, maps to held/press/release per key.
// Latency: outputs update 1 clk after the filtered stop-bit falling edge (plus line filter delay).
// No backpressure: all event outputs are single-cycle pulses; build macro PS2_KEYMAP_EXT_KEYS_EN.
module ps2_keymap_rx
  import ps2_pkg::*;
#(
  parameter int                            NUM_KEYS   = 12,
  parameter logic [NUM_KEYS*KEYCODE_W-1:0] KEY_CODES  = KEY_CODES_DEFAULT,
  parameter int                            CLK_HZ     = 100_000_000,
  parameter int                            TIMEOUT_US = 2000,
  parameter int                            FILT_LEN   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                kclk,
  input  logic                kdata,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                scan_valid,
  output logic [7:0]          scan_code,
  output logic                frame_err
);

  localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);

  // Filtered lines.
  logic kclk_f;
  logic kclk_fall;
  logic kdata_f;
  logic kdata_fall_unused;

  // Frame assembly.
  frame_state_t    state;
  frame_state_t    state_nxt;
  logic [7:0]      shreg;
  logic [2:0]      bit_cnt;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;

  // Per-cycle frame verdicts.
  logic to_hit;
  logic byte_good;
  logic stop_err;

  // Prefix tracking and key matching.
  logic                brk;
  logic                ext;
  logic                key_skip;
  logic [NUM_KEYS-1:0] key_hit;

  ps2_line_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_clk_filt (
    .clk  (clk),
    .rst  (rst),
    .raw  (kclk),
    .filt (kclk_f),
    .fall (kclk_fall)
  );

  // The data line is only sampled at clock edges, so its own edge strobe is not needed.
  ps2_line_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_data_filt (
    .clk  (clk),
    .rst  (rst),
    .raw  (kdata),
    .filt (kdata_f),
    .fall (kdata_fall_unused)
  );

  // A stalled frame is abandoned once the gap between clock edges reaches the limit.
  assign to_hit = (state != IDLE) && !kclk_fall && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next frame state: advance only on a filtered clock falling edge, or bail out on timeout.
  always_comb begin
    state_nxt = state;
    if (to_hit) begin
      state_nxt = IDLE;
    end else if (kclk_fall) begin
      case (state)
        IDLE:    if (!kdata_f) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Frame verdict at the stop bit: good byte or stop/parity error.
  always_comb begin
    byte_good = 1'b0;
    stop_err  = 1'b0;
    if (kclk_fall && (state == STOP)) begin
      if (kdata_f && odd_parity_ok(shreg, par_bit)) begin
        byte_good = 1'b1;
      end else begin
        stop_err = 1'b1;
      end
    end
  end

  // Data shift register (LSB first), bit counter and parity capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
    end else if (kclk_fall) begin
      case (state)
        IDLE:   bit_cnt <= '0;
        DATA: begin
          shreg   <= {kdata_f, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        PARITY: par_bit <= kdata_f;
        default: ;
      endcase
    end
  end

  // Inter-edge gap counter; idle time never counts towards a timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if ((state == IDLE) || kclk_fall || to_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

`ifdef PS2_KEYMAP_EXT_KEYS_EN
  // Extended keys are distinct table entries, so the E0 flag takes part in the match.
  assign key_skip = 1'b0;

  // Match the received byte (with its extended flag) against every table entry.
  always_comb begin
    key_hit = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      key_hit[i] = (KEY_CODES[i*KEYCODE_W +: KEYCODE_W] == {ext, shreg});
    end
  end
`else
  // Without extended support an E0 sequence is swallowed whole rather than aliasing a plain key.
  assign key_skip = ext;

  // Match the received byte against the code field of every entry; the ext bit is ignored.
  always_comb begin
    key_hit = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      key_hit[i] = (KEY_CODES[i*KEYCODE_W +: 8] == shreg);
    end
  end
`endif

  // Byte decode: prefix flags, key levels and edge-qualified press/release pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_valid  <= 1'b0;
      scan_code   <= '0;
      frame_err   <= 1'b0;
      brk         <= 1'b0;
      ext         <= 1'b0;
      key_held    <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      scan_valid  <= byte_good;
      frame_err   <= stop_err | to_hit;
      key_press   <= '0;
      key_release <= '0;
      if (stop_err || to_hit) begin
        // A broken frame may have been the second half of a sequence; forget the prefixes.
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (byte_good) begin
        scan_code <= shreg;
        if (shreg == PS2_BRK) begin
          brk <= 1'b1;
        end else if (shreg == PS2_EXT) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (!key_skip) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
              if (key_hit[i]) begin
                if (brk) begin
                  key_held[i]    <= 1'b0;
                  key_release[i] <= key_held[i];
                end else begin
                  // Typematic repeats of a held key raise no further press pulse.
                  key_held[i]  <= 1'b1;
                  key_press[i] <= ~key_held[i];
                end
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keymap_rx.sv
`timescale 1ns/1ps
module tb_ps2_keymap_rx;

  localparam int NK     = 14;
  localparam int FILT   = 8;
  localparam int TO_CYC = 200;   // CLK_HZ=1 MHz, TIMEOUT_US=200
  localparam int H      = 16;    // PS/2 half period in clk cycles
  // Entries 0..11: default layout; 12 = {1,0x75} arrow up; 13 = {0,0x75} keypad 8.
  localparam logic [NK*9-1:0] CODES = {
    9'h075, 9'h175, 9'h035, 9'h031, 9'h05A, 9'h04B, 9'h03B,
    9'h042, 9'h043, 9'h029, 9'h023, 9'h01C, 9'h01B, 9'h01D
  };
`ifdef PS2_KEYMAP_EXT_KEYS_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          kclk = 1'b1;
  logic          kdata = 1'b1;
  logic [NK-1:0] key_held;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic          scan_valid;
  logic [7:0]    scan_code;
  logic          frame_err;

  ps2_keymap_rx #(
    .NUM_KEYS   (NK),
    .KEY_CODES  (CODES),
    .CLK_HZ     (1_000_000),
    .TIMEOUT_US (200),
    .FILT_LEN   (FILT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .kclk        (kclk),
    .kdata       (kdata),
    .key_held    (key_held),
    .key_press   (key_press),
    .key_release (key_release),
    .scan_valid  (scan_valid),
    .scan_code   (scan_code),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling clock edge.
  int            n_valid = 0, n_err = 0, n_press = 0, n_rel = 0;
  int            valid_cyc = 0, err_cyc = 0;
  logic [NK-1:0] held_at_valid = '0, last_press = '0, last_rel = '0;
  logic [7:0]    code_at_valid = '0;
  always @(negedge clk) begin
    if (scan_valid) begin
      n_valid++;
      valid_cyc     = cyc;
      held_at_valid = key_held;
      code_at_valid = scan_code;
    end
    if (frame_err) begin
      n_err++;
      err_cyc = cyc;
    end
    if (key_press != '0) begin
      n_press++;
      last_press = key_press;
    end
    if (key_release != '0) begin
      n_rel++;
      last_rel = key_release;
    end
  end

  int         checks = 0;
  int         failures = 0;
  int         stop_cyc = 0;
  int         edge_cyc = 0;
  logic [7:0] last_code = '0;

  // Reference model state.
  logic [8:0]    tbl [NK];
  logic [NK-1:0] m_held = '0;
  bit            m_brk = 1'b0, m_ext = 1'b0;

  typedef struct {
    logic [7:0]    b;
    int            kind;   // 0 good, 1 bad parity, 2 bad stop
    logic [NK-1:0] ep;
    logic [NK-1:0] er;
    logic [NK-1:0] eh;
  } vec_t;
  vec_t tv [13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_rng(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the first nbits of a frame: start, 8 data LSB first, parity, stop.
  task automatic send_bits(input logic [7:0] b, input int kind, input int nbits);
    logic [10:0] fr;
    fr = {(kind == 2) ? 1'b0 : 1'b1, (~^b) ^ (kind == 1), b, 1'b0};
    for (int j = 0; j < nbits; j++) begin
      kdata = fr[j];
      wait_cyc(H);
      kclk = 1'b0;
      edge_cyc = cyc;
      if (j == 10) stop_cyc = cyc;
      wait_cyc(H);
      kclk = 1'b1;
    end
  endtask

  task automatic do_frame(input logic [7:0] b, input int kind,
                          input logic [NK-1:0] ep, input logic [NK-1:0] er,
                          input logic [NK-1:0] eh);
    int v0, e0, p0, r0;
    v0 = n_valid; e0 = n_err; p0 = n_press; r0 = n_rel;
    send_bits(b, kind, 11);
    kdata = 1'b1;
    wait_cyc(40);
    if (kind == 0) last_code = b;
    check("valid_count", 32'(n_valid - v0), (kind == 0) ? 32'd1 : 32'd0);
    check("err_count", 32'(n_err - e0), (kind == 0) ? 32'd0 : 32'd1);
    if (kind == 0) begin
      check_rng("valid_latency", valid_cyc - stop_cyc, FILT, FILT + 6);
      check("code_at_valid", 32'(code_at_valid), 32'(b));
      check("held_at_valid", 32'(held_at_valid), 32'(eh));
    end else begin
      check_rng("err_latency", err_cyc - stop_cyc, FILT, FILT + 6);
    end
    check("press_count", 32'(n_press - p0), (ep != '0) ? 32'd1 : 32'd0);
    if (ep != '0) check("press_vec", 32'(last_press), 32'(ep));
    check("release_count", 32'(n_rel - r0), (er != '0) ? 32'd1 : 32'd0);
    if (er != '0) check("release_vec", 32'(last_rel), 32'(er));
    check("key_held", 32'(key_held), 32'(eh));
    check("scan_code", 32'(scan_code), 32'(last_code));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(4);
    last_code = '0;
  endtask

  // Reference model: apply one received frame to the key state as the protocol defines it.
  task automatic model_step(input logic [7:0] b, input int kind,
                            output logic [NK-1:0] ep, output logic [NK-1:0] er);
    bit hit;
    ep = '0;
    er = '0;
    if (kind != 0) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else begin
      if (EXT_EN || !m_ext) begin
        for (int i = 0; i < NK; i++) begin
          hit = EXT_EN ? (tbl[i] == {m_ext, b}) : (tbl[i][7:0] == b);
          if (hit) begin
            if (m_brk) begin
              er[i] = m_held[i];
              m_held[i] = 1'b0;
            end else begin
              ep[i] = ~m_held[i];
              m_held[i] = 1'b1;
            end
          end
        end
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  initial begin
    int v0, e0;
    logic [7:0]    rb;
    int            rk;
    logic [NK-1:0] ep, er;
    logic [7:0]    pool [7];

    for (int i = 0; i < NK; i++) tbl[i] = CODES[i*9 +: 9];
    pool[0] = 8'h1D; pool[1] = 8'h1B; pool[2] = 8'h1C; pool[3] = 8'h23;
    pool[4] = 8'h75; pool[5] = 8'h5A; pool[6] = 8'h29;

    tv[0]  = '{8'h1D, 0, 14'h0001, 14'h0000, 14'h0001};
    tv[1]  = '{8'h1D, 0, 14'h0000, 14'h0000, 14'h0001};
    tv[2]  = '{8'h1D, 0, 14'h0000, 14'h0000, 14'h0001};
    tv[3]  = '{8'h1D, 0, 14'h0000, 14'h0000, 14'h0001};
    tv[4]  = '{8'hF0, 0, 14'h0000, 14'h0000, 14'h0001};
    tv[5]  = '{8'h1D, 0, 14'h0000, 14'h0001, 14'h0000};
    tv[6]  = '{8'h23, 0, 14'h0008, 14'h0000, 14'h0008};
    tv[7]  = '{8'h29, 1, 14'h0000, 14'h0000, 14'h0008};
    tv[8]  = '{8'h29, 2, 14'h0000, 14'h0000, 14'h0008};
    tv[9]  = '{8'hF0, 0, 14'h0000, 14'h0000, 14'h0008};
    tv[10] = '{8'h29, 1, 14'h0000, 14'h0000, 14'h0008};
    tv[11] = '{8'h23, 0, 14'h0000, 14'h0000, 14'h0008};
    tv[12] = '{8'h2A, 0, 14'h0000, 14'h0000, 14'h0008};

    // Reset state.
    wait_cyc(5);
    check("rst_held", 32'(key_held), 32'd0);
    check("rst_press", 32'(key_press), 32'd0);
    check("rst_release", 32'(key_release), 32'd0);
    check("rst_valid", 32'(scan_valid), 32'd0);
    check("rst_code", 32'(scan_code), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    wait_cyc(5);

    // Directed frame table.
    for (int t = 0; t < 13; t++) do_frame(tv[t].b, tv[t].kind, tv[t].ep, tv[t].er, tv[t].eh);

    // Break prefix, then a frame that stalls after 6 data bits: timeout must clear brk.
    do_frame(8'hF0, 0, '0, '0, 14'h0008);
    v0 = n_valid; e0 = n_err;
    send_bits(8'h1B, 0, 7);
    kdata = 1'b1;
    wait_cyc(TO_CYC + 60);
    check("timeout_err_count", 32'(n_err - e0), 32'd1);
    check("timeout_valid_count", 32'(n_valid - v0), 32'd0);
    check_rng("timeout_latency", err_cyc - edge_cyc, TO_CYC, TO_CYC + FILT + 8);
    do_frame(8'h1B, 0, 14'h0002, '0, 14'h000A);

    // Short low glitches on kclk (3 and FILT-1 cycles) with data low must not start a frame.
    v0 = n_valid; e0 = n_err;
    kdata = 1'b0;
    for (int g = 0; g < 4; g++) begin
      kclk = 1'b0;
      wait_cyc((g % 2 == 0) ? 3 : FILT - 1);
      kclk = 1'b1;
      wait_cyc(12);
    end
    kdata = 1'b1;
    wait_cyc(TO_CYC + 40);
    check("glitch_valid_count", 32'(n_valid - v0), 32'd0);
    check("glitch_err_count", 32'(n_err - e0), 32'd0);
    do_frame(8'h1C, 0, 14'h0004, '0, 14'h000E);

    // Extended prefix handling.
    do_frame(8'hE0, 0, '0, '0, 14'h000E);
    if (EXT_EN) begin
      do_frame(8'h75, 0, 14'h1000, '0, 14'h100E);
      do_frame(8'h75, 0, 14'h2000, '0, 14'h300E);
      do_frame(8'hE0, 0, '0, '0, 14'h300E);
      do_frame(8'hF0, 0, '0, '0, 14'h300E);
      do_frame(8'h75, 0, '0, 14'h1000, 14'h200E);
    end else begin
      do_frame(8'h75, 0, '0, '0, 14'h000E);
      do_frame(8'h75, 0, 14'h3000, '0, 14'h300E);
      do_frame(8'hE0, 0, '0, '0, 14'h300E);
      do_frame(8'hF0, 0, '0, '0, 14'h300E);
      do_frame(8'h75, 0, '0, '0, 14'h300E);
    end

    // Reset in the middle of a frame (after data bit 3, i.e. at bit 4).
    send_bits(8'h5A, 0, 5);
    v0 = n_valid; e0 = n_err;
    rst = 1'b1;
    wait_cyc(3);
    check("midrst_held", 32'(key_held), 32'd0);
    check("midrst_code", 32'(scan_code), 32'd0);
    check("midrst_press", 32'(key_press), 32'd0);
    kclk = 1'b1;
    kdata = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(30);
    last_code = '0;
    check("midrst_valid_count", 32'(n_valid - v0), 32'd0);
    check("midrst_err_count", 32'(n_err - e0), 32'd0);
    do_frame(8'h5A, 0, 14'h0200, '0, 14'h0200);

    // Randomized traffic against the reference model.
    pulse_reset();
    m_held = '0;
    m_brk  = 1'b0;
    m_ext  = 1'b0;
    for (int n = 0; n < 50; n++) begin
      rk = $urandom_range(0, 99);
      if (rk < 20)      rb = 8'hF0;
      else if (rk < 30) rb = 8'hE0;
      else if (rk < 80) rb = pool[$urandom_range(0, 6)];
      else              rb = 8'($urandom_range(0, 255));
      rk = $urandom_range(0, 99);
      rk = (rk < 85) ? 0 : ((rk < 93) ? 1 : 2);
      model_step(rb, rk, ep, er);
      do_frame(rb, rk, ep, er, m_held);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
